// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg -- shared VGA timing constants (1024x768 @ 60 Hz defaults),
// derived line/frame totals, and the per-axis flag bundle exchanged between
// vga_axis_counter and vga_timing_gen. Also used by vga_display.
package vga_timing_pkg;

    localparam int unsigned CW = 12;   // counter / coordinate width

    localparam int unsigned DEF_H_ACTIVE = 1024;
    localparam int unsigned DEF_H_FP     = 24;
    localparam int unsigned DEF_H_SYNCP  = 136;
    localparam int unsigned DEF_H_BP     = 160;
    localparam int unsigned DEF_V_ACTIVE = 768;
    localparam int unsigned DEF_V_FP     = 3;
    localparam int unsigned DEF_V_SYNCP  = 6;
    localparam int unsigned DEF_V_BP     = 29;
    localparam logic        DEF_HS_POL   = 1'b0;
    localparam logic        DEF_VS_POL   = 1'b0;

    // Blanking precedes the visible region, so the first visible position
    // is the sum of the three blanking intervals.
    function automatic int unsigned axis_start(input int unsigned fp,
                                               input int unsigned syncp,
                                               input int unsigned bp);
        return fp + syncp + bp;
    endfunction

    localparam int unsigned H_START = axis_start(DEF_H_FP, DEF_H_SYNCP, DEF_H_BP);
    localparam int unsigned V_START = axis_start(DEF_V_FP, DEF_V_SYNCP, DEF_V_BP);
    localparam int unsigned H_TOTAL = H_START + DEF_H_ACTIVE;
    localparam int unsigned V_TOTAL = V_START + DEF_V_ACTIVE;

    // Position flags of one axis, evaluated on its next-state count.
    typedef struct packed {
        logic sync;   // inside the sync pulse
        logic act;    // inside the visible region
        logic last;   // at TOTAL-1
    } axis_flags_t;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter -- one timing axis (horizontal or vertical).
//   clk, rst_n : pixel clock, asynchronous active-low reset
//   inc        : advance the count by one this cycle (wraps at TOTAL-1)
//   cnt_q      : registered position, 0..TOTAL-1
//   cnt_d      : next-state position, for aligned downstream registers
//   flags_d    : sync/active/last flags of cnt_d
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL      = H_TOTAL,
    parameter int unsigned SYNC_START = DEF_H_FP,
    parameter int unsigned SYNC_LEN   = DEF_H_SYNCP,
    parameter int unsigned ACT_START  = H_START
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [CW-1:0] cnt_q,
    output logic [CW-1:0] cnt_d,
    output axis_flags_t   flags_d
);

    localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SYNC_LO = CW'(SYNC_START);
    localparam logic [CW-1:0] SYNC_HI = CW'(SYNC_START + SYNC_LEN);
    localparam logic [CW-1:0] ACT_LO  = CW'(ACT_START);

    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            // >= rather than == keeps the count bounded even from a corrupt state
            cnt_d = (cnt_q >= LAST) ? '0 : cnt_q + 1'b1;
        end
        flags_d.sync = (cnt_d >= SYNC_LO) && (cnt_d < SYNC_HI);
        flags_d.act  = (cnt_d >= ACT_LO);
        flags_d.last = (cnt_d == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- VGA sync/blanking timing generator.
//   clk, rst_n        : pixel clock, asynchronous active-low reset
//   pix_en            : clock enable; timing advances only when high
//   h_counter/v_counter: raster position (0..H_TOTAL-1 / 0..V_TOTAL-1)
//   hs, vs            : sync outputs, asserted level HS_POL / VS_POL
//   video_active      : inside the visible area
//   active_x/active_y : visible-pixel coordinates, 0 outside the visible area
//   line_end/frame_end: markers at the last pixel of a line / of a frame
// Every output is a register loaded from next-state counter values, so all
// outputs describe the same raster position in every cycle.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNCP  = DEF_H_SYNCP,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNCP  = DEF_V_SYNCP,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        HS_POL   = DEF_HS_POL,
    parameter logic        VS_POL   = DEF_VS_POL
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_en,
    output logic [CW-1:0] h_counter,
    output logic [CW-1:0] v_counter,
    output logic          hs,
    output logic          vs,
    output logic          video_active,
    output logic [CW-1:0] active_x,
    output logic [CW-1:0] active_y,
    output logic          line_end,
    output logic          frame_end
);

    localparam int unsigned H_ST  = axis_start(H_FP, H_SYNCP, H_BP);
    localparam int unsigned V_ST  = axis_start(V_FP, V_SYNCP, V_BP);
    localparam int unsigned H_TOT = H_ST + H_ACTIVE;
    localparam int unsigned V_TOT = V_ST + V_ACTIVE;

    logic [CW-1:0] h_cnt_d, v_cnt_d;
    axis_flags_t   h_flags_d, v_flags_d;

    logic          hs_q, vs_q, video_active_q, line_end_q, frame_end_q;
    logic          hs_d, vs_d, video_active_d, line_end_d, frame_end_d;
    logic [CW-1:0] active_x_q, active_y_q, active_x_d, active_y_d;
    logic          v_inc;

    // line_end_q is high exactly while h_counter sits at H_TOTAL-1, so it
    // doubles as the horizontal-wrap strobe for the vertical axis.
    assign v_inc = pix_en & line_end_q;

    vga_axis_counter #(
        .TOTAL      (H_TOT),
        .SYNC_START (H_FP),
        .SYNC_LEN   (H_SYNCP),
        .ACT_START  (H_ST)
    ) u_h_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (pix_en),
        .cnt_q   (h_counter),
        .cnt_d   (h_cnt_d),
        .flags_d (h_flags_d)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOT),
        .SYNC_START (V_FP),
        .SYNC_LEN   (V_SYNCP),
        .ACT_START  (V_ST)
    ) u_v_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (v_inc),
        .cnt_q   (v_counter),
        .cnt_d   (v_cnt_d),
        .flags_d (v_flags_d)
    );

    always_comb begin
        hs_d           = h_flags_d.sync ? HS_POL : ~HS_POL;
        vs_d           = v_flags_d.sync ? VS_POL : ~VS_POL;
        video_active_d = h_flags_d.act & v_flags_d.act;
        active_x_d     = video_active_d ? h_cnt_d - CW'(H_ST) : '0;
        active_y_d     = video_active_d ? v_cnt_d - CW'(V_ST) : '0;
        line_end_d     = h_flags_d.last;
        frame_end_d    = h_flags_d.last & v_flags_d.last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q           <= ~HS_POL;
            vs_q           <= ~VS_POL;
            video_active_q <= 1'b0;
            active_x_q     <= '0;
            active_y_q     <= '0;
            line_end_q     <= 1'b0;
            frame_end_q    <= 1'b0;
        end else if (pix_en) begin
            hs_q           <= hs_d;
            vs_q           <= vs_d;
            video_active_q <= video_active_d;
            active_x_q     <= active_x_d;
            active_y_q     <= active_y_d;
            line_end_q     <= line_end_d;
            frame_end_q    <= frame_end_d;
        end
    end

    assign hs           = hs_q;
    assign vs           = vs_q;
    assign video_active = video_active_q;
    assign active_x     = active_x_q;
    assign active_y     = active_y_q;
    assign line_end     = line_end_q;
    assign frame_end    = frame_end_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, 1024, visible pixels per line.
REQ-002 SHALL have parameter H_FP, 24, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNCP, 136, horizontal sync width in clocks.
REQ-004 SHALL have parameter H_BP, 160, horizontal back porch in clocks.
REQ-005 SHALL have parameter V_ACTIVE, 768, visible lines per frame.
REQ-006 SHALL have parameter V_FP, 3, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNCP, 6, vertical sync width in lines.
REQ-008 SHALL have parameter V_BP, 29, vertical back porch in lines.
REQ-009 SHALL have parameters HS_POL, 1'b0, and VS_POL, 1'b0, giving the asserted sync levels.
REQ-010 SHALL have port clk, input, 1, pixel clock (65 MHz for the defaults); the block has one clock.
REQ-011 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-012 SHALL have port pix_en, input, 1, clock enable; the timing advances only in cycles where it is high.
REQ-013 SHALL have port h_counter, output, 12, horizontal position, 0..H_TOTAL-1.
REQ-014 SHALL have port v_counter, output, 12, vertical position, 0..V_TOTAL-1.
REQ-015 SHALL have ports hs and vs, output, 1 each, horizontal and vertical sync.
REQ-016 SHALL have port video_active, output, 1, high inside the visible area.
REQ-017 SHALL have ports active_x and active_y, output, 12 each, visible-pixel coordinates, 0 outside the visible area.
REQ-018 SHALL have ports line_end and frame_end, output, 1 each, single-cycle markers.

Function
REQ-019 H_TOTAL SHALL be H_FP+H_SYNCP+H_BP+H_ACTIVE (1344 for the defaults), and V_TOTAL SHALL be V_FP+V_SYNCP+V_BP+V_ACTIVE (806 for the defaults).
REQ-020 Each horizontal line SHALL run in this order: front porch, sync, back porch, active; H_START = H_FP+H_SYNCP+H_BP (320); vertical timing SHALL use the same order with V_START = V_FP+V_SYNCP+V_BP (38).
REQ-021 When pix_en=1, h_counter SHALL increment by 1, and when h_counter is H_TOTAL-1 it SHALL wrap to 0.
REQ-022 v_counter SHALL increment only when h_counter wraps, and SHALL wrap to 0 when v_counter is V_TOTAL-1 at that wrap.
REQ-023 When pix_en=0, all outputs SHALL hold their values, including line_end and frame_end.
REQ-024 hs SHALL equal HS_POL when H_FP <= h_counter < H_FP+H_SYNCP, and ~HS_POL otherwise.
REQ-025 vs SHALL equal VS_POL when V_FP <= v_counter < V_FP+V_SYNCP, and ~VS_POL otherwise; vs is evaluated per line and does not depend on h_counter.
REQ-026 video_active SHALL be 1 only when h_counter >= H_START and v_counter >= V_START.
REQ-027 When video_active=1, active_x SHALL be h_counter-H_START and active_y SHALL be v_counter-V_START; otherwise both SHALL be 0.
REQ-028 line_end SHALL be 1 exactly when h_counter = H_TOTAL-1.
REQ-029 frame_end SHALL be 1 exactly when line_end=1 and v_counter = V_TOTAL-1.
REQ-030 All outputs SHALL be registered and mutually aligned: in any cycle, every derived output reflects the h_counter/v_counter values of that same cycle (zero relative latency).
REQ-031 Derived outputs SHALL be computed from next-state counter values so that the alignment in REQ-030 holds without a cycle of skew.
REQ-032 No counter SHALL ever exceed its TOTAL-1 value under any pix_en pattern.

Reset
REQ-033 While rst_n=0, the outputs SHALL be: h_counter=0, v_counter=0, hs=~HS_POL, vs=~VS_POL, video_active=0, active_x=0, active_y=0, line_end=0, frame_end=0.
REQ-034 Assertion of rst_n SHALL take effect immediately, without waiting for a clock edge, including mid-line or mid-sync.
REQ-035 After rst_n deasserts, counting SHALL resume from (0,0) on the first clk edge with pix_en=1.

Structure
REQ-036 The timing defaults, the HS_POL/VS_POL defaults and the derived H_TOTAL/V_TOTAL/H_START/V_START constants SHALL live in the shared package vga_timing_pkg, which vga_display also uses.
REQ-037 SHALL instantiate one sub-module, vga_axis_counter, twice (horizontal and vertical), each with parameters TOTAL, SYNC_START, SYNC_LEN, ACT_START and inputs clk, rst_n, inc.

Verification
REQ-038 Free run with defaults and pix_en=1 -> line_end pulses every 1344 clocks; frame_end pulses every 1,083,264 clocks.
REQ-039 Sync timing -> hs is low for h_counter 24..159; vs is low for v_counter 3..8; both are high elsewhere.
REQ-040 Active window -> video_active is first high at (320,38) with active_x=0, active_y=0, and is last high at (1343,805) with active_x=1023, active_y=767.
REQ-041 pix_en toggled 1/0 every cycle -> counters advance once per two clocks and all outputs hold during pix_en=0, including a frame_end held for 2 clocks.
REQ-042 rst_n pulsed low at h_counter=100 (inside hs) -> hs=1 and counters=0 immediately; the next enabled edge gives h_counter=1.
REQ-043 Wrap at (1343,805) -> the next enabled cycle gives h_counter=0, v_counter=0 and frame_end=0.
